// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory initiator.
package lc3_mem_pkg;

  localparam int unsigned LC3_WORD_W  = 16;
  localparam int unsigned LC3_TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lc3_mem_state_e;

endpackage

// File: rtl/lc3_mem_timer.sv
// Access watchdog for the LC-3 memory initiator: counts ACCESS cycles and
// flags the cycle in which the count reaches MEM_TIMEOUT.
module lc3_mem_timer
  import lc3_mem_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [LC3_TIMER_W-1:0] cnt_q;
  logic [LC3_TIMER_W-1:0] cnt_d;

  // Clear wins over increment; hold when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + LC3_TIMER_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count reaches MEM_TIMEOUT at the edge closing this ACCESS cycle.
  assign expired = enable && (cnt_q == LC3_TIMER_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_initiator.sv
// LC-3 memory initiator: MAR/MDR plus an IDLE/ACCESS/DONE handshake with a
// memory whose R response lags MIO_EN by one cycle.
// Optional access timeout enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_mem_initiator
  import lc3_mem_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  LD_MAR,
  input  logic                  LD_MDR,
  input  logic                  req,
  input  logic                  R_W,
  input  logic [LC3_WORD_W-1:0] bus_in,
  output logic [LC3_WORD_W-1:0] mdr_out,
  output logic                  ready,
  output logic                  err,
  output logic                  MIO_EN,
  output logic                  RW,
  output logic [LC3_WORD_W-1:0] addr,
  output logic [LC3_WORD_W-1:0] data_in,
  input  logic [LC3_WORD_W-1:0] data_out,
  input  logic                  R
);

  // Reject out-of-range timeouts at elaboration.
  if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255)) begin : g_bad_timeout
    $error("lc3_mem_initiator: MEM_TIMEOUT must be in 2..255");
  end

  lc3_mem_state_e        state_q, state_d;
  logic [LC3_WORD_W-1:0] mar_q, mar_d;
  logic [LC3_WORD_W-1:0] mdr_q, mdr_d;
  logic [LC3_WORD_W-1:0] addr_q, addr_d;
  logic [LC3_WORD_W-1:0] data_in_q, data_in_d;
  logic                  mio_en_q, mio_en_d;
  logic                  rw_q, rw_d;
  logic                  ready_q, ready_d;

`ifdef LC3_MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic timer_clear_c;
  logic timer_en_c;
  logic timeout_c;

  lc3_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_c),
    .enable  (timer_en_c),
    .expired (timeout_c)
  );
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    addr_d    = addr_q;
    data_in_d = data_in_q;
    mio_en_d  = mio_en_q;
    rw_d      = rw_q;
    ready_d   = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
    err_d         = 1'b0;
    timer_clear_c = 1'b0;
    timer_en_c    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Loads apply before a same-cycle request so the access sees them.
        if (LD_MAR) mar_d = bus_in;
        if (LD_MDR) mdr_d = bus_in;
        if (req) begin
          rw_d      = R_W;
          mio_en_d  = 1'b1;
          addr_d    = mar_d;
          data_in_d = mdr_d;
          state_d   = ACCESS;
`ifdef LC3_MEM_TIMEOUT_EN
          timer_clear_c = 1'b1;
`endif
        end
      end
      ACCESS: begin
`ifdef LC3_MEM_TIMEOUT_EN
        timer_en_c = 1'b1;
`endif
        // A response in the timeout cycle still completes normally.
        if (R) begin
          if (!rw_q) mdr_d = data_out;
          mio_en_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
`ifdef LC3_MEM_TIMEOUT_EN
        else if (timeout_c) begin
          mio_en_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          state_d  = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mio_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      addr_q    <= '0;
      data_in_q <= '0;
      mio_en_q  <= 1'b0;
      rw_q      <= 1'b0;
      ready_q   <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
      mio_en_q  <= mio_en_d;
      rw_q      <= rw_d;
      ready_q   <= ready_d;
`ifdef LC3_MEM_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign mdr_out = mdr_q;
  assign ready   = ready_q;
  assign MIO_EN  = mio_en_q;
  assign RW      = rw_q;
  assign addr    = addr_q;
  assign data_in = data_in_q;

`ifdef LC3_MEM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
